axi_lite_mem_slave: RTL and testbench
=====================================

# axi_lite_mem_slave

Parametrised AXI-lite-style memory slave with independent write-address, write-data, write-response, read-address and read-data channels. Full valid/ready handshakes, per-byte write strobes, and OKAY/SLVERR responses. Word-addressed storage of DEPTH words. It is the register/memory endpoint for the bus masters in this design.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- DEPTH, 8, number of storage words
- ADDR_W, $clog2(DEPTH)+1, word-address width; the extra bit exists so out-of-range addresses can be presented
- STRB_W, DATA_W/8, derived; not overridable
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wa_addr  in  ADDR_W  write word address
- wa_valid  in  1  write address valid
- wa_ready  out  1  write address accepted
- wd_data  in  DATA_W  write data
- wd_strb  in  STRB_W  byte-lane enables; bit i covers bits 8i+7:8i
- wd_valid  in  1  write data valid
- wd_ready  out  1  write data accepted
- b_resp  out  2  write response; OKAY=2'b00, SLVERR=2'b10
- b_valid  out  1  write response valid
- b_ready  in  1  master accepts the write response
- ra_addr  in  ADDR_W  read word address
- ra_valid  in  1  read address valid
- ra_ready  out  1  read address accepted
- rd_data  out  DATA_W  read data
- rd_resp  out  2  read response, same encoding as b_resp
- rd_valid  out  1  read data valid
- rd_ready  in  1  master accepts the read data

## Operation
- Reset values: wa_ready=1, wd_ready=1, ra_ready=1, b_valid=0, b_resp=OKAY, rd_valid=0, rd_data=0, rd_resp=OKAY, all memory words=0, both hold flags clear.
- AW capture: a handshake (wa_valid && wa_ready) stores the address and sets aw_held. wa_ready = !aw_held (registered).
- W capture: a handshake stores data and strobe and sets w_held. wd_ready = !w_held. AW and W may arrive in either order or in the same cycle.
- Commit condition: aw_held && w_held && (!b_valid || b_ready).
  - On commit, if addr < DEPTH: update only the byte lanes with their strobe bit set, and set b_resp=OKAY.
  - If addr >= DEPTH: memory is untouched and b_resp=SLVERR.
  - The commit sets b_valid=1 and clears both hold flags.
- An all-zero strobe is a legal write: no data changes, OKAY.
- B channel: b_valid and b_resp hold stable until b_valid && b_ready. A new commit in the same cycle as that handshake keeps b_valid=1 with the new response.
- Read: ra_ready = !rd_valid, so one read is outstanding at a time.
  - On an AR handshake, rd_valid=1. rd_data takes mem[ra_addr] with rd_resp=OKAY, or 0 with SLVERR if out of range.
  - rd_data and rd_resp hold stable while rd_valid && !rd_ready. rd_valid clears on the rd_ready handshake.
- Read/write to the same address on the same edge: the read returns the pre-write contents.
- Inputs without their valid are ignored. The block never drives X or Z on any output.

## Timing
- AW and W handshakes complete by edge N: b_valid rises at edge N+1, provided the B channel is free.
- Back-pressure: while b_valid=1 && b_ready=0, a new AW/W pair may be captured but does not commit. wa_ready and wd_ready then stay low until the commit occurs.
- Sustained write throughput: one write per 2 cycles.
- AR handshake at edge N: rd_valid=1 with data valid after edge N. ra_ready is low from then until the edge of the rd_ready handshake. Peak read throughput is one read per 2 cycles.
- Asynchronous reset mid-transaction drops all held and pending state immediately. Outputs take their reset values without a clock edge. The first handshake is accepted at the first rising edge after reset_n deasserts.

## Structure
- Package axi_lite_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11)
  - localparam RESP_W=2
- Sub-module axi_lite_strb_mem: DEPTH x DATA_W array with byte-strobe write port, combinational read port, and asynchronous clear. All handshake logic lives in the top module.

## Test plan
- Reset, then AW addr=3 and W data=32'hDEADBEEF strb=4'hF in the same cycle, b_ready=1 → b_valid one cycle later with b_resp=OKAY. Reading addr=3 returns 32'hDEADBEEF with OKAY.
- W data=32'h11223344 strb=4'hF sent three cycles before AW addr=5 → no commit until AW arrives, then OKAY. Follow-up write to addr=5 with data=32'hAABBCCDD strb=4'b0101 → read gives 32'h11BB33DD.
- Write to addr=9 (DEPTH=8) → b_resp=SLVERR and no memory word changes. Read of addr=12 → rd_data=0, rd_resp=SLVERR.
- Hold b_ready=0 for 5 cycles after a write, then issue a second AW/W → second pair is captured but wa_ready/wd_ready stay 0. b_valid stays 1 with the first response; the second response appears the cycle after b_ready rises.
- rd_ready=0 for 4 cycles after reading addr=2 → rd_data stable, ra_ready=0 throughout. AR and W commit to addr=2 on the same edge → read returns the old value.
- Assert reset_n=0 between an AW handshake and its W → all outputs and memory return to reset values asynchronously. The stale AW is not committed when W arrives after reset.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-lite memory slave.
// Response encoding and index-width helper.
package axi_lite_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi_lite_strb_mem.sv
// Word array with byte-strobed write, async read
// and asynchronous clear.
module axi_lite_strb_mem
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '{default: '0};
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-lite style memory slave: AW/W/B and AR/R
// channels over a byte-strobed word array.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   wa_addr,
  input  logic                wa_valid,
  output logic                wa_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,
  input  logic                wd_valid,
  output logic                wd_ready,
  output logic [1:0]          b_resp,
  output logic                b_valid,
  input  logic                b_ready,
  input  logic [ADDR_W-1:0]   ra_addr,
  input  logic                ra_valid,
  output logic                ra_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [1:0]          rd_resp,
  output logic                rd_valid,
  input  logic                rd_ready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} < DEPTH_C;
  endfunction

  logic                aw_held;
  logic [ADDR_W-1:0]   aw_addr;
  logic                w_held;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                b_valid_q;
  resp_t               b_resp_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  resp_t               rd_resp_q;

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                commit;
  logic                aw_ok;
  logic                ar_ok;
  logic [DATA_W-1:0]   mem_rdata;

  assign aw_hs  = wa_valid && !aw_held;
  assign w_hs   = wd_valid && !w_held;
  assign ar_hs  = ra_valid && !rd_valid_q;
  assign aw_ok  = in_range(aw_addr);
  assign ar_ok  = in_range(ra_addr);
  assign commit = aw_held && w_held &&
                  (!b_valid_q || b_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_held <= 1'b0;
      aw_addr <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
    end else if (aw_hs) begin
      aw_held <= 1'b1;
      aw_addr <= wa_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_held <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (commit) begin
      w_held <= 1'b0;
    end else if (w_hs) begin
      w_held <= 1'b1;
      w_data <= wd_data;
      w_strb <= wd_strb;
    end
  end

  // A commit on the B handshake edge re-arms b_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_valid_q <= 1'b0;
      b_resp_q  <= OKAY;
    end else if (commit) begin
      b_valid_q <= 1'b1;
      b_resp_q  <= aw_ok ? OKAY : SLVERR;
    end else if (b_ready) begin
      b_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_resp_q  <= OKAY;
    end else if (ar_hs) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= ar_ok ? mem_rdata : '0;
      rd_resp_q  <= ar_ok ? OKAY : SLVERR;
    end else if (rd_ready) begin
      rd_valid_q <= 1'b0;
    end
  end

  axi_lite_strb_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (commit && aw_ok),
    .waddr   (aw_addr[IDX_W-1:0]),
    .wdata   (w_data),
    .wstrb   (w_strb),
    .raddr   (ra_addr[IDX_W-1:0]),
    .rdata   (mem_rdata)
  );

  assign wa_ready = !aw_held;
  assign wd_ready = !w_held;
  assign ra_ready = !rd_valid_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_resp  = rd_resp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave:
// directed writes/reads, monitor checks B and R.
module tb_axi_lite_mem_slave;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;
  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] wa_addr;
  logic              wa_valid;
  logic              wa_ready;
  logic [DATA_W-1:0] wd_data;
  logic [3:0]        wd_strb;
  logic              wd_valid;
  logic              wd_ready;
  logic [1:0]        b_resp;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] ra_addr;
  logic              ra_valid;
  logic              ra_ready;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic              rd_valid;
  logic              rd_ready;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  always #5 clk = ~clk;

  axi_lite_mem_slave #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wa_addr  (wa_addr),
    .wa_valid (wa_valid),
    .wa_ready (wa_ready),
    .wd_data  (wd_data),
    .wd_strb  (wd_strb),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .b_resp   (b_resp),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .ra_addr  (ra_addr),
    .ra_valid (ra_valid),
    .ra_ready (ra_ready),
    .rd_data  (rd_data),
    .rd_resp  (rd_resp),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h",
               nm, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes
  // at the following posedge.
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge clk);
      if (reset_n && b_valid && b_ready) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected actual=%b expected=none",
                   b_resp);
        end else begin
          eb = exp_b.pop_front();
          chk("b_resp", 64'(b_resp), 64'(eb));
        end
      end
      if (reset_n && rd_valid && rd_ready) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected actual=%h expected=none",
                   rd_data);
        end else begin
          er = exp_r.pop_front();
          chk("r_data_resp", 64'({rd_data, rd_resp}),
              64'(er));
        end
      end
    end
  end

  task automatic hs_write(input bit do_aw,
                          input bit do_w,
                          input logic [ADDR_W-1:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    bit ah;
    bit wh;
    int n;
    n = 0;
    wa_addr  = a;
    wd_data  = d;
    wd_strb  = s;
    wa_valid = do_aw;
    wd_valid = do_w;
    while ((wa_valid || wd_valid) && n < 50) begin
      @(negedge clk);
      ah = wa_valid && wa_ready;
      wh = wd_valid && wd_ready;
      @(posedge clk);
      #1;
      if (ah) wa_valid = 1'b0;
      if (wh) wd_valid = 1'b0;
      n++;
    end
    if (wa_valid || wd_valid) begin
      checks++;
      errors++;
      $display("FAIL write_timeout actual=stuck expected=handshake");
      wa_valid = 1'b0;
      wd_valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bit h;
    int n;
    n = 0;
    ra_addr  = a;
    ra_valid = 1'b1;
    while (ra_valid && n < 50) begin
      @(negedge clk);
      h = ra_ready;
      @(posedge clk);
      #1;
      if (h) ra_valid = 1'b0;
      n++;
    end
    if (ra_valid) begin
      checks++;
      errors++;
      $display("FAIL read_timeout actual=stuck expected=handshake");
      ra_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0 ||
            b_valid || rd_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
      exp_b.delete();
      exp_r.delete();
    end
  endtask

  task automatic push_r(input logic [31:0] d,
                        input logic [1:0] r);
    exp_r.push_back({d, r});
  endtask

  initial begin
    reset_n  = 1'b0;
    wa_addr  = '0;
    wa_valid = 1'b0;
    wd_data  = '0;
    wd_strb  = '0;
    wd_valid = 1'b0;
    b_ready  = 1'b1;
    ra_addr  = '0;
    ra_valid = 1'b0;
    rd_ready = 1'b1;

    #2;
    chk("rst_wa_ready", 64'(wa_ready), 64'd1);
    chk("rst_wd_ready", 64'(wd_ready), 64'd1);
    chk("rst_ra_ready", 64'(ra_ready), 64'd1);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_b_resp", 64'(b_resp), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_resp", 64'(rd_resp), 64'd0);
    #20;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Same-cycle AW+W, then latency of b_valid
    push_r(32'h0, OK);
    rd(4'd7);
    exp_b.push_back(OK);
    hs_write(1, 1, 4'd3, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("b_lat_n", 64'(b_valid), 64'd0);
    @(negedge clk);
    chk("b_lat_n1", 64'(b_valid), 64'd1);
    @(posedge clk);
    #1;
    push_r(32'hDEADBEEF, OK);
    rd(4'd3);
    wait_idle();

    // W first, AW three cycles later; then partial strobe
    hs_write(0, 1, 4'd0, 32'h11223344, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("w_only_no_b", 64'(b_valid), 64'd0);
      chk("w_only_wd_ready", 64'(wd_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    exp_b.push_back(OK);
    hs_write(1, 0, 4'd5, 32'h0, 4'h0);
    exp_b.push_back(OK);
    hs_write(1, 1, 4'd5, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    push_r(32'h11BB33DD, OK);
    rd(4'd5);
    wait_idle();

    // Out of range write and read
    exp_b.push_back(SE);
    hs_write(1, 1, 4'd9, 32'hCAFEF00D, 4'hF);
    wait_idle();
    push_r(32'h0, OK);
    rd(4'd1);
    push_r(32'hDEADBEEF, OK);
    rd(4'd3);
    push_r(32'h11BB33DD, OK);
    rd(4'd5);
    push_r(32'h0, SE);
    rd(4'd12);
    wait_idle();

    // Zero strobe leaves data intact
    exp_b.push_back(OK);
    hs_write(1, 1, 4'd3, 32'h0, 4'h0);
    wait_idle();
    push_r(32'hDEADBEEF, OK);
    rd(4'd3);
    wait_idle();

    // B back-pressure with a second pair queued
    b_ready = 1'b0;
    exp_b.push_back(OK);
    hs_write(1, 1, 4'd0, 32'h01020304, 4'hF);
    repeat (5) @(negedge clk);
    chk("bp_b_valid", 64'(b_valid), 64'd1);
    @(posedge clk);
    #1;
    exp_b.push_back(SE);
    hs_write(1, 1, 4'd8, 32'h0BADBAD0, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("bp_wa_ready", 64'(wa_ready), 64'd0);
      chk("bp_wd_ready", 64'(wd_ready), 64'd0);
      chk("bp_b_hold", 64'({b_valid, b_resp}),
          64'({1'b1, OK}));
    end
    @(posedge clk);
    #1;
    b_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_second", 64'({b_valid, b_resp}),
        64'({1'b1, SE}));
    chk("bp_wa_free", 64'(wa_ready), 64'd1);
    wait_idle();
    push_r(32'h01020304, OK);
    rd(4'd0);
    wait_idle();

    // R back-pressure, then read/write collision
    exp_b.push_back(OK);
    hs_write(1, 1, 4'd2, 32'h55667788, 4'hF);
    wait_idle();
    rd_ready = 1'b0;
    push_r(32'h55667788, OK);
    rd(4'd2);
    repeat (4) begin
      @(negedge clk);
      chk("rs_hold", 64'({rd_valid, rd_data, rd_resp}),
          64'({1'b1, 32'h55667788, OK}));
      chk("rs_ra_ready", 64'(ra_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_idle();
    exp_b.push_back(OK);
    hs_write(1, 1, 4'd2, 32'h99AABBCC, 4'hF);
    push_r(32'h55667788, OK);
    rd(4'd2);
    wait_idle();
    push_r(32'h99AABBCC, OK);
    rd(4'd2);
    wait_idle();

    // Reset between AW and W
    hs_write(1, 0, 4'd4, 32'h0, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_wa_ready", 64'(wa_ready), 64'd1);
    chk("ar_outs", 64'({b_valid, rd_valid, rd_data}),
        64'd0);
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    hs_write(0, 1, 4'd0, 32'h12345678, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("ar_stale_aw", 64'(b_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    exp_b.push_back(OK);
    hs_write(1, 0, 4'd6, 32'h0, 4'h0);
    wait_idle();
    push_r(32'h12345678, OK);
    rd(4'd6);
    push_r(32'h0, OK);
    rd(4'd4);
    push_r(32'h0, OK);
    rd(4'd2);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
